// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Rebuilds pixel_x / pixel_y / active from incoming hsync/vsync and checks the
//   line/frame timing against the configured VGA geometry.  Locks after
//   LOCK_FRAMES clean frames and drops lock (with a timing_error pulse) on the
//   first deviation.  All outputs are registered and lag the sync inputs by two
//   clock cycles.
//   Optional feature macro: VGA_SYNC_DEC_ERRCNT_EN enables the saturating
//   timing-error counter on err_count; otherwise err_count is tied to zero.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [15:0] line_len,
    output logic [7:0]  err_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Column/line that the leading sync edges mark, and the one after it
    localparam logic [9:0] H_REF   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] V_REF   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
    localparam logic [7:0] FRAMES_TGT = 8'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_H_ALIGN = 2'd1;
    localparam logic [1:0] ST_V_CHECK = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    logic        hs_q, vs_q, hs_d, vs_d;
    logic        hs_edge, vs_edge;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_wrap;
    logic [9:0]  h_inc, v_inc, h_next, v_next;
    logic        h_pos_ok, v_pos_ok;
    logic        h_seen, v_seen;
    logic        h_miss, v_miss, h_bad, v_bad;
    logic [1:0]  state, state_n;
    logic [7:0]  frames_ok, frames_n;
    logic        h_ok, h_ok_n;
    logic        lock_err;
    logic        at_origin;
    logic        locked_n;
    logic [15:0] len_cnt;

    // Register the sync inputs once, keep one more stage for edge detection
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            hs_d <= ~SYNC_POL;
            vs_d <= ~SYNC_POL;
        end else begin
            hs_q <= hsync_in;
            vs_q <= vsync_in;
            hs_d <= hs_q;
            vs_d <= vs_q;
        end
    end

    assign hs_edge = (hs_q == SYNC_POL) && (hs_d != SYNC_POL);
    assign vs_edge = (vs_q == SYNC_POL) && (vs_d != SYNC_POL);

    // Free-running position, then the reloads the sync edges impose
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_inc  = h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap)
            v_inc = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        else
            v_inc = v_cnt;
        // vsync reload wins over the line increment caused by an h wrap
        h_next   = hs_edge ? H_REF : h_inc;
        v_next   = vs_edge ? V_REF : v_inc;
        h_pos_ok = (h_inc == H_REF);
        v_pos_ok = (v_inc == V_REF);
        // A missing edge is declared once the counter has moved past the
        // reference point without an edge having been seen at it
        h_miss   = !hs_edge && (h_cnt == H_REF) && !h_seen;
        v_miss   = !vs_edge && h_wrap && (v_cnt == V_REF) && !v_seen;
        h_bad    = (hs_edge && !h_pos_ok) || h_miss;
        v_bad    = (vs_edge && !v_pos_ok) || v_miss;
    end

    // Position counters and the per-line / per-frame "edge seen" flags
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            h_seen <= 1'b0;
            v_seen <= 1'b0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (hs_edge)
                h_seen <= 1'b1;
            else if (h_cnt == H_REF)
                h_seen <= 1'b0;
            if (vs_edge)
                v_seen <= 1'b1;
            else if (h_wrap && (v_cnt == V_REF))
                v_seen <= 1'b0;
        end
    end

    // Lock acquisition / supervision state machine
    always_comb begin
        state_n  = state;
        frames_n = frames_ok;
        h_ok_n   = h_ok;
        lock_err = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (hs_edge) begin
                    state_n = ST_H_ALIGN;
                    h_ok_n  = 1'b0;
                end
            end
            ST_H_ALIGN: begin
                if (hs_edge)
                    h_ok_n = h_pos_ok;
                if (vs_edge) begin
                    state_n  = ST_V_CHECK;
                    frames_n = '0;
                end
            end
            ST_V_CHECK: begin
                if (hs_edge)
                    h_ok_n = h_pos_ok;
                if (h_bad || v_bad) begin
                    state_n = ST_H_ALIGN;
                    h_ok_n  = 1'b0;
                end else if (vs_edge) begin
                    if (!h_ok_n) begin
                        state_n = ST_H_ALIGN;
                    end else begin
                        frames_n = frames_ok + 8'd1;
                        if (frames_n == FRAMES_TGT)
                            state_n = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_bad || v_bad) begin
                    lock_err = 1'b1;
                    state_n  = ST_SEARCH;
                end
            end
            default: state_n = ST_SEARCH;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state     <= ST_SEARCH;
            frames_ok <= '0;
            h_ok      <= 1'b0;
        end else begin
            state     <= state_n;
            frames_ok <= frames_n;
            h_ok      <= h_ok_n;
        end
    end

    // locked rises only at the first (0,0) after the FSM reaches LOCKED
    always_comb begin
        at_origin = (h_next == '0) && (v_next == '0);
        locked_n  = (state == ST_LOCKED) && !lock_err && (locked || at_origin);
    end

    // Registered pixel-domain outputs
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            pixel_x      <= '0;
            pixel_y      <= '0;
            active       <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
        end else begin
            pixel_x      <= locked_n ? h_next : '0;
            pixel_y      <= locked_n ? v_next : '0;
            active       <= locked_n && (h_next < H_ACT_L) && (v_next < V_ACT_L);
            frame_start  <= locked_n && at_origin;
            locked       <= locked_n;
            timing_error <= lock_err;
        end
    end

    // hsync-to-hsync period measurement; once the running count saturates the
    // reported length goes to 0xFFFF without waiting for an edge that may never come
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            len_cnt  <= '0;
            line_len <= '0;
        end else begin
            if (hs_edge) begin
                len_cnt  <= '0;
                line_len <= (len_cnt == 16'hFFFF) ? 16'hFFFF : len_cnt + 16'd1;
            end else begin
                if (len_cnt != 16'hFFFF)
                    len_cnt <= len_cnt + 16'd1;
                else
                    line_len <= 16'hFFFF;
            end
        end
    end

`ifdef VGA_SYNC_DEC_ERRCNT_EN
    // Saturating count of timing errors, cleared only by reset
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (lock_err && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Drives a reduced-geometry VGA sync generator into the decoder.  Each driven
//   pixel pushes its expected decoder output into a queue that is popped two
//   cycles later when the decoder presents that pixel.
module tb_vga_sync_decoder;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int HREF = HA + HFP;
    localparam int VREF = VA + VFP;

    logic        clk_25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [9:0]  pixel_x, pixel_y;
    logic        active, frame_start, locked, timing_error;
    logic [15:0] line_len;
    logic [7:0]  err_count;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .active      (active),
        .frame_start (frame_start),
        .locked      (locked),
        .timing_error(timing_error),
        .line_len    (line_len),
        .err_count   (err_count)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int unsigned cyc = 0;
    always @(posedge clk_25MHz) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        bit          chk_pix;
        logic [23:0] pix;
        bit          chk_len;
        logic [15:0] len;
        bit          chk_ec;
        logic [7:0]  ec;
        int          tag;
    } sb_t;

    sb_t sb[$];
    sb_t ce;

    int n_checks = 0;
    int n_errors = 0;

    // generator / expectation state
    int gh = 0, gv = 0, gf = 0;
    bit exp_locked = 0;
    int vs_left = 3;
    bit vs_prev = 0;
    int exp_errs = 0;
    int dup_f = -1, sup_f = -1;
    bit dup_done = 0, skipping = 0, post_hold = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tag_name(input int t);
        case (t)
            1: return "frame_start";
            2: return "active_edge";
            3: return "timing_error";
            4: return "frame_wrap";
            5: return "hold_unlocked";
            default: return "pixel";
        endcase
    endfunction

    function automatic logic [7:0] exp_ec();
`ifdef VGA_SYNC_DEC_ERRCNT_EN
        return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
        return 8'h00;
`endif
    endfunction

    // Pop and compare every expectation whose output cycle has arrived
    always @(negedge clk_25MHz) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            ce = sb.pop_front();
            if (ce.due != cyc)
                check_val("sb_order", 64'(cyc), 64'(ce.due));
            if (ce.chk_pix)
                check_val(tag_name(ce.tag),
                          64'({pixel_x, pixel_y, active, frame_start, locked, timing_error}),
                          64'(ce.pix));
            if (ce.chk_len)
                check_val("line_len", 64'(line_len), 64'(ce.len));
            if (ce.chk_ec)
                check_val("err_count", 64'(err_count), 64'(ce.ec));
        end
    end

    // One generator pixel: drive sync, push the expected decoder output, advance
    task automatic drive_pixel();
        bit   in_hs, in_vs, err_here, want_len;
        logic [15:0] exp_len;
        sb_t  e;
        @(posedge clk_25MHz);
        #1;
        in_hs = (gh >= HREF) && (gh < HREF + HS);
        in_vs = (gv >= VREF) && (gv < VREF + VS) && (gf != sup_f);
        hsync_in = ~in_hs;
        vsync_in = ~in_vs;

        err_here = 0;
        want_len = 0;
        exp_len  = 16'(HT);
        e.chk_pix = !skipping;
        if (gf == dup_f && gv == 3 && gh == HREF) begin
            err_here  = 1;
            skipping  = 0;
            e.chk_pix = 1;
            want_len  = 1;
            exp_len   = 16'(HT + 1);
        end
        if (gf == sup_f && gv == VREF + 1 && gh == 0)
            err_here = 1;

        if (in_vs && !vs_prev && vs_left != 0)
            vs_left--;
        vs_prev = in_vs;

        if (err_here) begin
            exp_locked = 0;
            vs_left    = 3;
            exp_errs++;
        end else if (gh == 0 && gv == 0 && vs_left == 0) begin
            exp_locked = 1;
        end

        if (exp_locked && gh == HREF)
            want_len = 1;
        if (post_hold && gh == HREF && gv < 2) begin
            want_len = 1;
            exp_len  = (gv == 0) ? 16'hFFFF : 16'(HT);
        end

        if (exp_locked)
            e.pix = {10'(gh), 10'(gv), (gh < HA) && (gv < VA), (gh == 0) && (gv == 0), 1'b1, 1'b0};
        else
            e.pix = {20'd0, 1'b0, 1'b0, 1'b0, err_here};

        if (err_here)                                 e.tag = 3;
        else if (gh == 0 && gv == 0)                  e.tag = 1;
        else if (gv == VA - 1 && (gh == HA - 1 || gh == HA)) e.tag = 2;
        else if (gh == HT - 1 && gv == VT - 1)        e.tag = 4;
        else                                          e.tag = 0;

        e.due     = cyc + 2;
        e.chk_len = want_len;
        e.len     = exp_len;
        e.chk_ec  = err_here || (exp_locked && gh == 0 && gv == 0);
        e.ec      = exp_ec();
        sb.push_back(e);

        if (gf == dup_f && gv == 3 && gh == 5 && !dup_done) begin
            dup_done = 1;
            skipping = 1;
        end else begin
            gh++;
            if (gh == HT) begin
                gh = 0;
                gv++;
                if (gv == VT) begin
                    gv = 0;
                    gf++;
                end
            end
        end
    endtask

    task automatic run_until(input int f, input int v);
        int guard;
        guard = 0;
        while (!(gf == f && gv == v && gh == 0) && guard < 20000) begin
            drive_pixel();
            guard++;
        end
        if (guard >= 20000)
            check_val("run_bound", 64'(guard), 64'(0));
    endtask

    initial begin
        sb_t h;
        // reset state
        repeat (3) @(posedge clk_25MHz);
        #1;
        check_val("reset_out",
                  64'({pixel_x, pixel_y, active, frame_start, locked, timing_error, line_len, err_count}),
                  64'(0));
        rst = 1'b0;

        // nominal lock (locked from frame 3), then one long line in frame 5
        dup_f = 5;
        run_until(9, 0);
        // one suppressed vsync pulse in frame 10, relock by frame 14
        sup_f = 10;
        run_until(15, 8);

        // asynchronous reset in the middle of a locked frame
        #5;
        rst = 1'b1;
        sb.delete();
        #1;
        check_val("rst_async",
                  64'({pixel_x, pixel_y, active, frame_start, locked, timing_error, line_len, err_count}),
                  64'(0));
        @(negedge clk_25MHz);
        check_val("rst_next",
                  64'({pixel_x, pixel_y, active, frame_start, locked, timing_error, line_len, err_count}),
                  64'(0));
        @(posedge clk_25MHz);
        #1;
        rst = 1'b0;
        gh = 0; gv = 0; gf = 0;
        exp_locked = 0; vs_left = 3; vs_prev = 0; exp_errs = 0;
        dup_f = -1; sup_f = -1; skipping = 0;

        // hsync held asserted: no lock, line length saturates
        for (int i = 0; i < 66000; i++) begin
            @(posedge clk_25MHz);
            #1;
            hsync_in = 1'b0;
            vsync_in = 1'b1;
            h.due = cyc + 2; h.chk_pix = 1; h.pix = '0;
            h.chk_len = 0; h.len = '0; h.chk_ec = 0; h.ec = '0; h.tag = 5;
            sb.push_back(h);
        end
        repeat (3) @(negedge clk_25MHz);
        check_val("len_sat", 64'(line_len), 64'(16'hFFFF));
        check_val("no_x",
                  64'($isunknown({pixel_x, pixel_y, active, frame_start, locked, timing_error, line_len, err_count})),
                  64'(0));

        // release: first edge reports the saturated period, the next a normal line
        post_hold = 1;
        run_until(0, 2);

        repeat (4) @(negedge clk_25MHz);
        check_val("sb_drain", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
